piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_bit_counter.sv | 41 ++++
 rtl/piso_serializer.sv | 140 ++++++++++++++
 tb/tb_piso_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN adds a trailing even-parity bit
// and the PARITY state.
package piso_pkg;

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;
`endif

    // Level driven on s_out whenever no frame bit is being presented.
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial frame: synchronous clear, count enable,
// and a terminal-count flag when the count reaches N-1. It holds at N-1
// rather than wrapping, so a frame can never restart its bit index by accident.
module piso_bit_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise step up until the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register, forced to zero by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer. A word accepted on a valid/ready edge
// is shifted out one bit per cycle starting the next cycle, MSB or LSB first.
// in_ready reopens in the final bit cycle so frames can stream back to back.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity bit.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         s_out,
    output logic         frame,
    output logic         last
);

    piso_state_e  state_q;
    piso_state_e  state_d;
    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;
    logic         s_out_q;
    logic         s_out_d;
    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;
    logic         accept;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic         parity_q;
    logic         parity_d;
`endif

    // First bit to leave a word, according to the configured bit order.
    function automatic logic head_bit(input logic [N-1:0] w);
        return (MSB_FIRST != 0) ? w[N-1] : w[0];
    endfunction

    // Word with its leading bit removed, ready to present the next one.
    function automatic logic [N-1:0] drop_head(input logic [N-1:0] w);
        return (MSB_FIRST != 0) ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    piso_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    assign accept = in_valid && in_ready;

    // Next-state, shift and output-bit logic; an accept always starts a fresh frame.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        s_out_d = s_out_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                s_out_d = IDLE_LEVEL;
            end
            SHIFT: begin
                if (!cnt_tc) begin
                    cnt_en  = 1'b1;
                    s_out_d = head_bit(shreg_q);
                    shreg_d = drop_head(shreg_q);
                end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_d = PARITY;
                    s_out_d = parity_q;
`else
                    state_d = IDLE;
                    s_out_d = IDLE_LEVEL;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                s_out_d = IDLE_LEVEL;
            end
`endif
            default: begin
                state_d = IDLE;
                s_out_d = IDLE_LEVEL;
            end
        endcase

        if (accept) begin
            state_d = SHIFT;
            cnt_clr = 1'b1;
            s_out_d = head_bit(in_data);
            shreg_d = drop_head(in_data);
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_d = ^in_data;
`endif
        end
    end

    // State, shift register and serial output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            s_out_q  <= IDLE_LEVEL;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            s_out_q  <= s_out_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Handshake and framing flags decode straight from registered state.
    assign s_out = s_out_q;
    assign frame = (state_q != IDLE);
`ifdef PISO_SERIALIZER_PARITY_EN
    assign last     = (state_q == PARITY);
    assign in_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign last     = (state_q == SHIFT) && cnt_tc;
    assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_tc);
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (N=8). Two instances share stimulus:
// one MSB-first, one LSB-first. A queue-based reference model lists the
// expected per-cycle outputs of every accepted frame.
module tb_piso_serializer;

    localparam int N = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = N + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         rdy_m, sout_m, frame_m, last_m;
    logic         rdy_l, sout_l, frame_l, last_l;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic b_msb;
        logic b_lsb;
        logic lst;
    } exp_bit_t;

    exp_bit_t q[$];

    logic cap_m, cap_l;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_msb;   // emitted order, first bit in bit 7
        logic [7:0] seq_lsb;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    piso_serializer #(.N(N), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .s_out(sout_m), .frame(frame_m), .last(last_m)
    );

    piso_serializer #(.N(N), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .s_out(sout_l), .frame(frame_l), .last(last_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Model: a word expands into FL expected bit cycles.
    task automatic push_frame(input logic [N-1:0] d);
        exp_bit_t r;
        for (int k = 0; k < N; k++) begin
            r.b_msb = d[N-1-k];
            r.b_lsb = d[k];
            r.lst   = (k == N-1) && !PAR;
            q.push_back(r);
        end
        if (PAR) begin
            r.b_msb = ^d;
            r.b_lsb = ^d;
            r.lst   = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic check_outputs();
        logic e_frame, e_rdy, e_last, e_bm, e_bl;
        e_frame = (q.size() > 0);
        e_rdy   = (q.size() <= 1);
        e_last  = e_frame ? q[0].lst : 1'b0;
        e_bm    = e_frame ? q[0].b_msb : 1'b0;
        e_bl    = e_frame ? q[0].b_lsb : 1'b0;
        chk("frame_m", frame_m, e_frame);
        chk("ready_m", rdy_m, e_rdy);
        chk("last_m", last_m, e_last);
        chk("sout_m", sout_m, e_bm);
        chk("frame_l", frame_l, e_frame);
        chk("ready_l", rdy_l, e_rdy);
        chk("last_l", last_l, e_last);
        chk("sout_l", sout_l, e_bl);
        cap_m = sout_m;
        cap_l = sout_l;
        $display("cyc t=%0t v=%b d=%h rdy=%b frm=%b lst=%b s=%b/%b", $time, in_valid,
                 in_data, rdy_m, frame_m, last_m, sout_m, sout_l);
    endtask

    // One clock: check current outputs, drive inputs, advance model at the edge.
    task automatic cycle(input logic v, input logic [N-1:0] d);
        logic acc;
        check_outputs();
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        acc = v && (q.size() <= 1) && !rst;
        if (q.size() > 0) void'(q.pop_front());
        if (acc) push_frame(d);
        @(negedge clk);
    endtask

    initial begin
        logic [17:0] acc_m, acc_l;
        logic [17:0] exp18;

        vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
        vecs[2] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0};
        vecs[3] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
        vecs[4] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
        vecs[5] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();          // reset state
        rst = 1'b0;

        // Table: single frames, serial stream compared with constant sequences.
        for (int i = 0; i < 6; i++) begin
            acc_m = '0;
            acc_l = '0;
            cycle(1'b1, vecs[i].data);
            for (int k = 0; k < FL; k++) begin
                cycle(1'b0, 8'h00);
                acc_m = {acc_m[16:0], cap_m};
                acc_l = {acc_l[16:0], cap_l};
            end
            cycle(1'b0, 8'h00);   // back in idle
            if (PAR) begin
                chk8("tbl_msb", acc_m, {9'd0, vecs[i].seq_msb, vecs[i].par});
                chk8("tbl_lsb", acc_l, {9'd0, vecs[i].seq_lsb, vecs[i].par});
            end else begin
                chk8("tbl_msb", acc_m, {10'd0, vecs[i].seq_msb});
                chk8("tbl_lsb", acc_l, {10'd0, vecs[i].seq_lsb});
            end
        end

        // Back-to-back: in_valid held high, F0 then 0F.
        acc_m = '0;
        cycle(1'b1, 8'hF0);
        for (int k = 0; k < FL; k++) begin
            cycle(1'b1, 8'h0F);
            acc_m = {acc_m[16:0], cap_m};
        end
        for (int k = 0; k < FL; k++) begin
            cycle(1'b0, 8'h00);
            acc_m = {acc_m[16:0], cap_m};
        end
        exp18 = PAR ? {8'hF0, 1'b0, 8'h0F, 1'b0} : {2'b00, 16'hF00F};
        chk8("b2b_stream", acc_m, exp18);

        // in_valid with 0xFF during cycle 4 of a frame must be ignored.
        acc_m = '0;
        cycle(1'b1, 8'hA5);
        for (int k = 1; k <= FL; k++) begin
            cycle((k == 4), (k == 4) ? 8'hFF : 8'h00);
            acc_m = {acc_m[16:0], cap_m};
        end
        cycle(1'b0, 8'h00);
        exp18 = PAR ? {9'd0, 8'hA5, 1'b0} : {10'd0, 8'hA5};
        chk8("ignore_valid", acc_m, exp18);

        // Reset in cycle 5 of a frame: outputs drop at once, next frame clean.
        cycle(1'b1, 8'hC3);
        for (int k = 1; k <= 4; k++) cycle(1'b0, 8'h00);
        check_outputs();          // cycle 5 before reset
        rst = 1'b1;
        #1;
        chk("rst_sout", sout_m, 1'b0);
        chk("rst_frame", frame_m, 1'b0);
        chk("rst_ready", rdy_m, 1'b1);
        chk("rst_last", last_m, 1'b0);
        chk("rst_sout_l", sout_l, 1'b0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc_m = '0;
        cycle(1'b1, 8'h3C);
        for (int k = 0; k < FL; k++) begin
            cycle(1'b0, 8'h00);
            acc_m = {acc_m[16:0], cap_m};
        end
        cycle(1'b0, 8'h00);
        exp18 = PAR ? {9'd0, 8'h3C, 1'b0} : {10'd0, 8'h3C};
        chk8("post_rst_3c", acc_m, exp18);

        // Random valid/data against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        for (int i = 0; i < FL + 2; i++) cycle(1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
